// File: rtl/ram_dumper_pkg.sv
// Shared types and constants for the UART RAM read-back engine.
// Clock/baud defaults mirror the programmer side of the SoC.
package ram_dumper_pkg;

    localparam int CPU_CLK             = 50_000_000;
    localparam int PROG_BAUD_RATE      = 115_200;
    localparam int BLK_SIZE            = 128;
    localparam int DUMP_BYTES_PER_WORD = 4;
    localparam int DUMP_FRAME_BITS     = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_LOAD,
        ST_SEND,
        ST_NEXT,
        ST_DONE
    } dump_state_e;

endpackage

// File: rtl/ram_rd_if.sv
// Line-read port of the cache-line RAM.
// The dumper is the master; the RAM wrapper is the slave.
interface ram_rd_if
    import ram_dumper_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = BLK_SIZE
);
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output rd_en, output addr, input rdata);
    modport slave  (input rd_en, input addr, output rdata);
endinterface

// File: rtl/ram_dumper_tx.sv
// 8N1 byte transmitter with a valid/ready byte input.
// ready rises in the last stop-bit cycle so frames chain without a gap.
module uart_tx_byte
    import ram_dumper_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
)(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_BIT = 4'(DUMP_FRAME_BITS - 1);

    logic          active;
    logic [3:0]    bit_idx;
    logic [CW-1:0] cnt;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end = (cnt == CNT_MAX);
    assign ready   = !active || (bit_idx == LAST_BIT && bit_end);

    // Baud counter and bit sequencer: start bit, 8 data bits LSB first, stop bit
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active  <= 1'b0;
            bit_idx <= '0;
            cnt     <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else if (valid && ready) begin
            active  <= 1'b1;
            bit_idx <= '0;
            cnt     <= '0;
            shreg   <= data;
            tx      <= 1'b0;
        end else if (active) begin
            if (bit_end) begin
                cnt <= '0;
                if (bit_idx == LAST_BIT) begin
                    active <= 1'b0;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    tx      <= (bit_idx == LAST_BIT - 4'd1) ? 1'b1
                                                            : shreg[bit_idx[2:0]];
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/ram_dumper.sv
// UART read-back engine: fetches RAM lines and sends words LSB byte first.
// Words within an already buffered line are sent without a new RAM read.
module ram_dumper
    import ram_dumper_pkg::*;
#(
    parameter int CLK_FREQ         = CPU_CLK,
    parameter int BAUD_RATE        = PROG_BAUD_RATE,
    parameter int ADDR_WIDTH       = 15,
    parameter int CACHE_LINE_WIDTH = BLK_SIZE,
    parameter int WORD_WIDTH       = 32
)(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   word_cnt_i,
    ram_rd_if.master              ram,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int LW = $clog2(CACHE_LINE_WIDTH / WORD_WIDTH);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("CLKS_PER_BIT must be >= 2");
        end
        if (WORD_WIDTH != 32) begin : g_bad_word
            $error("WORD_WIDTH must be 32");
        end
        if (LW < 1) begin : g_bad_line
            $error("line must hold at least two words");
        end
    endgenerate

    dump_state_e                 state;
    logic [ADDR_WIDTH-1:0]       cur_addr;
    logic [ADDR_WIDTH:0]         remaining;
    logic [CACHE_LINE_WIDTH-1:0] line_buf;
    logic                        buf_valid;
    logic [31:0]                 shift_word;
    logic [1:0]                  byte_idx;
    logic                        rd_en;

    logic [CACHE_LINE_WIDTH-1:0] src_line;
    logic [LW-1:0]               sel;
    logic [31:0]                 sel_word;
    logic [ADDR_WIDTH-1:0]       nxt_addr;
    logic [7:0]                  u_data;
    logic                        u_valid;
    logic                        u_ready;

    assign ram.rd_en = rd_en;
    assign ram.addr  = cur_addr;

    assign src_line = buf_valid ? line_buf : ram.rdata;
    assign sel      = cur_addr[LW-1:0];
    assign sel_word = src_line[{sel, 5'b0} +: 32];
    assign nxt_addr = cur_addr + ADDR_WIDTH'(1);

    // Byte 0 comes straight from the selected word; later bytes from the shifter
    always_comb begin
        u_valid = (state == ST_LOAD) || (state == ST_SEND);
        u_data  = (state == ST_LOAD) ? sel_word[7:0] : shift_word[7:0];
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .data  (u_data),
        .valid (u_valid),
        .ready (u_ready),
        .tx    (tx_o)
    );

    // Dump sequencer: fetch, buffer, byte sequencing and completion
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            cur_addr   <= '0;
            remaining  <= '0;
            line_buf   <= '0;
            buf_valid  <= 1'b0;
            shift_word <= '0;
            byte_idx   <= '0;
            rd_en      <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            rd_en  <= 1'b0;
            done_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        cur_addr  <= base_addr_i;
                        remaining <= word_cnt_i;
                        buf_valid <= 1'b0;
                        busy_o    <= 1'b1;
                        if (word_cnt_i == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_FETCH;
                            rd_en <= 1'b1;
                        end
                    end
                end
                ST_FETCH: state <= ST_WAIT;
                ST_WAIT:  state <= ST_LOAD;
                ST_LOAD: begin
                    if (!buf_valid) begin
                        line_buf  <= ram.rdata;
                        buf_valid <= 1'b1;
                    end
                    if (u_ready) begin
                        shift_word <= {8'h00, sel_word[31:8]};
                        byte_idx   <= 2'd1;
                        state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (u_ready) begin
                        shift_word <= {8'h00, shift_word[31:8]};
                        byte_idx   <= byte_idx + 2'd1;
                        if (byte_idx == 2'(DUMP_BYTES_PER_WORD - 1)) begin
                            state <= ST_NEXT;
                        end
                    end
                end
                ST_NEXT: begin
                    cur_addr  <= nxt_addr;
                    remaining <= remaining - (ADDR_WIDTH + 1)'(1);
                    if (remaining == (ADDR_WIDTH + 1)'(1)) begin
                        state <= ST_DONE;
                    end else if (nxt_addr[LW-1:0] == '0) begin
                        state     <= ST_FETCH;
                        rd_en     <= 1'b1;
                        buf_valid <= 1'b0;
                    end else begin
                        state <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    if (u_ready) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
